// File: rtl/yuyv_camera_emulator_if.sv
// Pixel stream into the camera emulator: 24-bit RGB with ready/valid handshake.
interface yuyv_camera_emulator_if;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/yuyv_camera_emulator.sv
// Camera sensor stand-in: buffers RGB pixels, converts pairs to YUYV and
// emits one byte per pixel_clock framed by registered vsync/href.
module yuyv_camera_emulator #(
    parameter int unsigned WIDTH        = 640,
    parameter int unsigned HEIGHT       = 480,
    parameter int unsigned HBLANK       = 144,
    parameter int unsigned VSYNC_LINES  = 3,
    parameter int unsigned VBACK_LINES  = 17,
    parameter int unsigned VFRONT_LINES = 10
) (
    input  logic                         pixel_clock,
    input  logic                         reset,
    yuyv_camera_emulator_if.slave        pixel_in,
    output logic [7:0]                   camera_data,
    output logic                         href,
    output logic                         vsync,
    output logic                         underrun,
    output logic                         frame_done
);

    localparam int unsigned LINE_LEN    = 2 * WIDTH + HBLANK;
    localparam int unsigned FRAME_LINES = VSYNC_LINES + VBACK_LINES + HEIGHT + VFRONT_LINES;
    localparam int unsigned COL_W       = $clog2(LINE_LEN);
    localparam int unsigned LINE_W      = $clog2(FRAME_LINES + 1);

    localparam logic [COL_W-1:0]  COL_LAST     = COL_W'(LINE_LEN - 1);
    localparam logic [COL_W-1:0]  ACT_COLS     = COL_W'(2 * WIDTH);
    localparam logic [COL_W-1:0]  ACT_LAST_COL = COL_W'(2 * WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST    = LINE_W'(FRAME_LINES - 1);
    localparam logic [LINE_W-1:0] VS_END       = LINE_W'(VSYNC_LINES);
    localparam logic [LINE_W-1:0] ACT_FIRST    = LINE_W'(VSYNC_LINES + VBACK_LINES);
    localparam logic [LINE_W-1:0] ACT_END      = LINE_W'(VSYNC_LINES + VBACK_LINES + HEIGHT);
    localparam logic [31:0]       BLACK_GROUP  = {8'd128, 8'd16, 8'd128, 8'd16};

    function automatic logic signed [17:0] chan(input logic [7:0] c);
        return $signed({10'd0, c});
    endfunction

    function automatic logic [7:0] sat8(input logic signed [17:0] v);
        if (v < 18'sd0)
            return 8'd0;
        else if (v > 18'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    function automatic logic [7:0] to_y(input logic [23:0] p);
        return sat8(((18'sd66 * chan(p[23:16]) + 18'sd129 * chan(p[15:8])
                    + 18'sd25 * chan(p[7:0]) + 18'sd128) >>> 8) + 18'sd16);
    endfunction

    function automatic logic [7:0] to_u(input logic [23:0] p);
        return sat8(((-18'sd38 * chan(p[23:16]) - 18'sd74 * chan(p[15:8])
                    + 18'sd112 * chan(p[7:0]) + 18'sd128) >>> 8) + 18'sd128);
    endfunction

    function automatic logic [7:0] to_v(input logic [23:0] p);
        return sat8(((18'sd112 * chan(p[23:16]) - 18'sd94 * chan(p[15:8])
                    - 18'sd18 * chan(p[7:0]) + 18'sd128) >>> 8) + 18'sd128);
    endfunction

    logic [COL_W-1:0]  col, col_next;
    logic [LINE_W-1:0] line, line_inc, line_next;
    logic              col_wrap, active_line, next_active, href_now;
    logic              load, pair_ok, push, pop;

    logic [23:0]       fifo_mem [4];
    logic [1:0]        rd_ptr, wr_ptr;
    logic [2:0]        count, count_next;
    logic              ready;
    logic [23:0]       p0, p1;
    logic [3:0][7:0]   group, loaded_group;

    assign pixel_in.in_ready = ready;

    always_comb begin
        col_wrap    = (col == COL_LAST);
        col_next    = col_wrap ? '0 : col + 1'b1;
        line_inc    = (line == LINE_LAST) ? '0 : line + 1'b1;
        line_next   = col_wrap ? line_inc : line;
        active_line = (line >= ACT_FIRST) && (line < ACT_END);
        next_active = (line_inc >= ACT_FIRST) && (line_inc < ACT_END);
        href_now    = active_line && (col < ACT_COLS);
        // Decide a group one cycle ahead of its Y1 byte: mid-line groups, or the first group of the next line.
        load        = (active_line && (col < ACT_LAST_COL) && (col[1:0] == 2'd3))
                    || (col_wrap && next_active);
        pair_ok     = (count >= 3'd2);
        pop         = load && pair_ok;
        push        = pixel_in.in_valid && ready;
        count_next  = count + {2'b00, push} - {1'b0, pop, 1'b0};
    end

    always_comb begin
        p0           = fifo_mem[rd_ptr];
        p1           = fifo_mem[rd_ptr + 2'd1];
        loaded_group = pair_ok ? {to_v(p0), to_y(p1), to_u(p0), to_y(p0)} : BLACK_GROUP;
    end

    always_ff @(posedge pixel_clock) begin
        if (push)
            fifo_mem[wr_ptr] <= pixel_in.in_data;
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            col         <= '0;
            line        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            ready       <= 1'b0;
            group       <= BLACK_GROUP;
            camera_data <= '0;
            href        <= 1'b0;
            vsync       <= 1'b0;
            underrun    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            col    <= col_next;
            line   <= line_next;
            count  <= count_next;
            ready  <= (count_next < 3'd4);
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd2;
            if (load)
                group <= loaded_group;

            vsync       <= (line < VS_END);
            href        <= href_now;
            camera_data <= href_now ? group[col[1:0]] : '0;
            frame_done  <= col_wrap && (line == LINE_LAST);
            if ((col == '0) && (line == '0))
                underrun <= 1'b0;
            else if (load && !pair_ok)
                underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_yuyv_camera_emulator.sv
// Self-checking bench for yuyv_camera_emulator in a small frame configuration:
// table vectors, hand-written corner sequences and a random run against a queue model.
module tb_yuyv_camera_emulator;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int HB = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int LL = 2 * W + HB;
    localparam int FL = VS + VB + H + VF;

    logic       pixel_clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] camera_data;
    logic       href, vsync, underrun, frame_done;

    yuyv_camera_emulator_if pix();

    yuyv_camera_emulator #(
        .WIDTH(W), .HEIGHT(H), .HBLANK(HB),
        .VSYNC_LINES(VS), .VBACK_LINES(VB), .VFRONT_LINES(VF)
    ) dut (
        .pixel_clock(pixel_clock),
        .reset(reset),
        .pixel_in(pix),
        .camera_data(camera_data),
        .href(href),
        .vsync(vsync),
        .underrun(underrun),
        .frame_done(frame_done)
    );

    always #5 pixel_clock = ~pixel_clock;

    typedef enum int {S_VS, S_HREF, S_FD, S_UR, S_DATA, S_RDY} sel_e;
    typedef struct { int c; sel_e sel; int exp; } tvec_t;
    typedef struct { logic [23:0] p0; logic [23:0] p1; logic [7:0] b[4]; } cvec_t;

    int checks = 0;
    int failures = 0;
    int cyc = -1;

    tvec_t       tq[$];
    cvec_t       ct[4];
    logic [23:0] src[$];

    logic       cap_vs[256], cap_href[256], cap_fd[256], cap_ur[256], cap_rdy[256];
    logic [7:0] cap_data[256];

    // Reference model: pixel queue plus expected outputs derived from the frame position
    logic [23:0] q[$];
    int          mt = 0;
    int          grp[4] = '{16, 128, 16, 128};
    logic        e_rdy = 1'b0, e_href = 1'b0, e_vs = 1'b0, e_ur = 1'b0, e_fd = 1'b0;
    logic [7:0]  e_data = 8'd0;

    function automatic int clamp(int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic int y_of(logic [23:0] p);
        int r = int'(p[23:16]); int g = int'(p[15:8]); int b = int'(p[7:0]);
        return clamp(((66 * r + 129 * g + 25 * b + 128) >>> 8) + 16);
    endfunction

    function automatic int u_of(logic [23:0] p);
        int r = int'(p[23:16]); int g = int'(p[15:8]); int b = int'(p[7:0]);
        return clamp(((-38 * r - 74 * g + 112 * b + 128) >>> 8) + 128);
    endfunction

    function automatic int v_of(logic [23:0] p);
        int r = int'(p[23:16]); int g = int'(p[15:8]); int b = int'(p[7:0]);
        return clamp(((112 * r - 94 * g - 18 * b + 128) >>> 8) + 128);
    endfunction

    function automatic bit href_at(int col, int line);
        return (line >= VS + VB) && (line < VS + VB + H) && (col < 2 * W);
    endfunction

    task automatic check(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, c, got, exp);
        end
    endtask

    task automatic model_edge();
        int col, line, ncol, nline;
        logic [23:0] a, b;
        bit push;
        if (reset) begin
            q.delete();
            mt = 0;
            {e_rdy, e_href, e_vs, e_ur, e_fd} = '0;
            e_data = '0;
        end else begin
            col   = mt % LL;
            line  = (mt / LL) % FL;
            ncol  = (mt + 1) % LL;
            nline = ((mt + 1) / LL) % FL;
            push  = pix.in_valid && e_rdy;
            e_vs   = (line < VS);
            e_href = href_at(col, line);
            e_fd   = (col == LL - 1) && (line == FL - 1);
            e_data = e_href ? 8'(grp[col % 4]) : 8'd0;
            if (col == 0 && line == 0) e_ur = 1'b0;
            if (href_at(ncol, nline) && (ncol % 4 == 0)) begin
                if (q.size() >= 2) begin
                    a = q.pop_front();
                    b = q.pop_front();
                    grp = '{y_of(a), u_of(a), y_of(b), v_of(a)};
                end else begin
                    grp = '{16, 128, 16, 128};
                    e_ur = 1'b1;
                end
            end
            if (push) q.push_back(pix.in_data);
            e_rdy = (q.size() < 4);
            mt++;
        end
    endtask

    task automatic tick();
        @(posedge pixel_clock);
        model_edge();
        if (reset) cyc = -1; else cyc++;
        @(negedge pixel_clock);
        check("m_vsync", cyc, vsync, e_vs);
        check("m_href", cyc, href, e_href);
        check("m_frame_done", cyc, frame_done, e_fd);
        check("m_underrun", cyc, underrun, e_ur);
        check("m_data", cyc, camera_data, e_data);
        check("m_in_ready", cyc, pix.in_ready, e_rdy);
        if (cyc >= 0 && cyc < 256) begin
            cap_vs[cyc]   = vsync;
            cap_href[cyc] = href;
            cap_fd[cyc]   = frame_done;
            cap_ur[cyc]   = underrun;
            cap_rdy[cyc]  = pix.in_ready;
            cap_data[cyc] = camera_data;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        pix.in_valid = 1'b0;
        src.delete();
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic run_feed(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            if (src.size() > 0) begin
                pix.in_valid = 1'b1;
                pix.in_data  = src[0];
            end else begin
                pix.in_valid = 1'b0;
            end
            acc = pix.in_valid && pix.in_ready;
            tick();
            if (acc) void'(src.pop_front());
        end
    endtask

    function automatic void add(int c, sel_e s, int e);
        tvec_t v;
        v.c = c; v.sel = s; v.exp = e;
        tq.push_back(v);
    endfunction

    function automatic logic [31:0] cap_get(sel_e s, int c);
        case (s)
            S_VS:    return {31'd0, cap_vs[c]};
            S_HREF:  return {31'd0, cap_href[c]};
            S_FD:    return {31'd0, cap_fd[c]};
            S_UR:    return {31'd0, cap_ur[c]};
            S_DATA:  return {24'd0, cap_data[c]};
            default: return {31'd0, cap_rdy[c]};
        endcase
    endfunction

    task automatic apply_tab(input string tag);
        foreach (tq[i])
            check($sformatf("%s_%s", tag, tq[i].sel.name()), tq[i].c, cap_get(tq[i].sel, tq[i].c), tq[i].exp);
        tq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        ct[0].p0 = 24'hFF0000; ct[0].p1 = 24'h000000; ct[0].b = '{8'd82,  8'd90,  8'd16,  8'd240};
        ct[1].p0 = 24'hFFFFFF; ct[1].p1 = 24'hFFFFFF; ct[1].b = '{8'd235, 8'd128, 8'd235, 8'd128};
        ct[2].p0 = 24'h00FF00; ct[2].p1 = 24'h0000FF; ct[2].b = '{8'd144, 8'd54,  8'd41,  8'd34};
        ct[3].p0 = 24'h0000FF; ct[3].p1 = 24'hFF0000; ct[3].b = '{8'd41,  8'd240, 8'd82,  8'd110};
        pix.in_valid = 1'b0;
        pix.in_data  = '0;

        // Reset state
        do_reset(3);
        check("rst_data", cyc, camera_data, 0);
        check("rst_href", cyc, href, 0);
        check("rst_vsync", cyc, vsync, 0);
        check("rst_ready", cyc, pix.in_ready, 0);
        check("rst_underrun", cyc, underrun, 0);
        check("rst_frame_done", cyc, frame_done, 0);

        // Frame timing with no pixels supplied
        run_feed(62);
        add(0, S_VS, 1);    add(11, S_VS, 1);   add(12, S_VS, 0);   add(60, S_VS, 1);
        add(23, S_HREF, 0); add(24, S_HREF, 1); add(31, S_HREF, 1); add(32, S_HREF, 0);
        add(35, S_HREF, 0); add(36, S_HREF, 1); add(43, S_HREF, 1); add(44, S_HREF, 0);
        add(58, S_FD, 0);   add(59, S_FD, 1);   add(60, S_FD, 0);
        add(22, S_UR, 0);   add(23, S_UR, 1);   add(59, S_UR, 1);   add(60, S_UR, 0);
        add(24, S_DATA, 16); add(25, S_DATA, 128); add(26, S_DATA, 16); add(27, S_DATA, 128);
        add(32, S_DATA, 0); add(0, S_RDY, 1);
        apply_tab("idle");

        // Colour vectors: one frame of four pairs
        do_reset(2);
        for (int g = 0; g < 4; g++) begin
            src.push_back(ct[g].p0);
            src.push_back(ct[g].p1);
        end
        run_feed(62);
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (VS + VB + g / (W / 2)) * LL + 4 * (g % (W / 2)) + k;
                check($sformatf("colour%0d_byte%0d", g, k), c, cap_data[c], ct[g].b[k]);
            end
        add(59, S_UR, 0);
        apply_tab("colour");

        // Backpressure with constant white
        do_reset(2);
        repeat (100) src.push_back(24'hFFFFFF);
        run_feed(62);
        add(3, S_RDY, 1);  add(4, S_RDY, 0);  add(22, S_RDY, 0); add(23, S_RDY, 1);
        add(24, S_RDY, 1); add(25, S_RDY, 0);
        add(24, S_DATA, 235); add(37, S_DATA, 128); add(42, S_DATA, 235);
        add(59, S_UR, 0);
        apply_tab("bp");

        // Only one pair per frame
        do_reset(2);
        src.push_back(24'hFF0000);
        src.push_back(24'h000000);
        run_feed(62);
        add(24, S_DATA, 82); add(25, S_DATA, 90); add(26, S_DATA, 16); add(27, S_DATA, 240);
        add(28, S_DATA, 16); add(29, S_DATA, 128);
        add(26, S_UR, 0); add(27, S_UR, 1); add(59, S_UR, 1);
        apply_tab("short");

        // Reset in the middle of an active line
        do_reset(2);
        repeat (100) src.push_back(24'hFFFFFF);
        run_feed(30);
        check("mid_pre_href", cyc, href, 1);
        reset = 1'b1;
        pix.in_valid = 1'b0;
        src.delete();
        tick();
        check("mid_href", cyc, href, 0);
        check("mid_data", cyc, camera_data, 0);
        check("mid_ready", cyc, pix.in_ready, 0);
        reset = 1'b0;
        run_feed(30);
        add(0, S_VS, 1); add(0, S_HREF, 0); add(0, S_RDY, 1);
        add(23, S_UR, 1); add(24, S_DATA, 16);
        apply_tab("mid");

        // Random traffic over several frames
        do_reset(2);
        for (int f = 0; f < 4; f++) begin
            int pct;
            pct = (f == 0) ? 60 : ((f == 1) ? 8 : ((f == 2) ? 30 : 15));
            for (int i = 0; i < FL * LL; i++) begin
                pix.in_valid = ($urandom_range(0, 99) < pct);
                pix.in_data  = 24'($urandom);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
